// File: rtl/mbist_pkg.sv
// Shared types and defaults for the memory BIST scheduler.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FINISH
    } mbist_sched_state_t;

    localparam int MBIST_NMEM_DEFAULT    = 4;
    localparam int MBIST_TIMEOUT_DEFAULT = 65536;

endpackage

// File: rtl/mbist_next_idx.sv
// Priority encoder: lowest set bit of en strictly above pos (pos = -1 searches from bit 0).
module mbist_next_idx #(
    parameter int NMEM = 4,
    parameter int IW   = 2
) (
    input  logic [NMEM-1:0] en,
    input  logic signed [IW:0] pos,
    output logic [IW-1:0]   nxt,
    output logic            found
);

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        // descending scan so the lowest qualifying index is the one left standing
        for (int i = NMEM - 1; i >= 0; i--) begin
            if (en[i] && (i > int'(pos))) begin
                nxt   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbist_sched.sv
// mbist_sched: runs enabled memory BIST engines one at a time and aggregates pass/fail.
// Optional per-engine watchdog is built when MBIST_SCHED_WATCHDOG_EN is defined.
module mbist_sched
    import mbist_pkg::*;
#(
    parameter int NMEM    = MBIST_NMEM_DEFAULT,
    parameter int TIMEOUT = MBIST_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NMEM-1:0] mem_en,
    output logic [NMEM-1:0] mem_start,
    input  logic [NMEM-1:0] mem_done,
    input  logic [NMEM-1:0] mem_fail,
    output logic            busy,
    output logic            done,
    output logic [NMEM-1:0] fail_map,
    output logic            fail,
    output logic [NMEM-1:0] timeout_map
);

    localparam int IW = (NMEM > 1) ? $clog2(NMEM) : 1;

    mbist_sched_state_t state, state_d;
    logic [NMEM-1:0]    en_q, en_d;
    logic [IW-1:0]      idx, idx_d;
    logic [NMEM-1:0]    mem_start_d, fail_map_d;
    logic               busy_d, done_d;

    logic [NMEM-1:0]    enc_en;
    logic signed [IW:0] enc_pos;
    logic [IW-1:0]      enc_idx;
    logic               enc_found;
    logic               cur_done, cur_fail, tmo_hit;

    assign cur_done = mem_done[idx];
    assign cur_fail = mem_fail[idx];

    // in IDLE the live mask is searched from the bottom; afterwards the captured mask above idx
    assign enc_en  = (state == IDLE) ? mem_en : en_q;
    assign enc_pos = (state == IDLE) ? {(IW+1){1'b1}} : {1'b0, idx};

    mbist_next_idx #(.NMEM(NMEM), .IW(IW)) u_next (
        .en    (enc_en),
        .pos   (enc_pos),
        .nxt   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        state_d     = state;
        en_d        = en_q;
        idx_d       = idx;
        mem_start_d = '0;
        fail_map_d  = fail_map;
        case (state)
            IDLE: if (start) begin
                en_d       = mem_en;
                fail_map_d = '0;
                if (enc_found) begin
                    idx_d       = enc_idx;
                    mem_start_d = NMEM'(1) << enc_idx;
                    state_d     = LAUNCH;
                end else begin
                    state_d = FINISH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                // the first engine of a run was already pulsed on the accepting edge
                if (mem_start == '0)
                    mem_start_d = NMEM'(1) << idx;
            end
            WAIT: if (cur_done || tmo_hit) begin
                fail_map_d[idx] = cur_done ? cur_fail : 1'b1;
                if (enc_found) begin
                    idx_d   = enc_idx;
                    state_d = LAUNCH;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LAUNCH) || (state_d == WAIT);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            en_q      <= '0;
            idx       <= '0;
            mem_start <= '0;
            fail_map  <= '0;
            fail      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            en_q      <= en_d;
            idx       <= idx_d;
            mem_start <= mem_start_d;
            fail_map  <= fail_map_d;
            fail      <= |fail_map_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef MBIST_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    // a done arriving on the expiry cycle takes precedence over the timeout
    assign tmo_hit = (state == WAIT) && !cur_done && (wd_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timeout_map <= '0;
        end else begin
            if (state == LAUNCH)
                wd_cnt <= '0;
            else if (state == WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == IDLE && start)
                timeout_map <= '0;
            else if (tmo_hit)
                timeout_map[idx] <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_map = '0;
`endif

endmodule

// File: tb/tb_mbist_sched.sv
// Bench for mbist_sched: timestamp-based run model checked every cycle, plus pinned cycle literals.
module tb_mbist_sched;

    localparam int NMEM = 4;
    localparam int TMO  = 100;
`ifdef MBIST_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start = 1'b0;
    logic [NMEM-1:0] mem_en = '0;
    logic [NMEM-1:0] mem_start, mem_done = '0, mem_fail = '0;
    logic            busy, done, fail;
    logic [NMEM-1:0] fail_map, timeout_map;

    mbist_sched #(.NMEM(NMEM), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_en      (mem_en),
        .mem_start   (mem_start),
        .mem_done    (mem_done),
        .mem_fail    (mem_fail),
        .busy        (busy),
        .done        (done),
        .fail_map    (fail_map),
        .fail        (fail),
        .timeout_map (timeout_map)
    );

    always #5 clk = ~clk;

    // engine behaviour knobs (latency 0 = engine never answers)
    int              lat_cfg [NMEM] = '{default: 20};
    logic [NMEM-1:0] fail_cfg  = '0;
    logic [NMEM-1:0] spur_done = '0;

    // ---------------- run model: ordered engine list + event timestamps ----------------
    int              cyc = 0;
    bit              running = 1'b0;
    int              cur = -1, pulse_at = -1, done_at = -1, wait_from = 0;
    int              todo [$];
    logic [NMEM-1:0] m_fail_map = '0, m_tmo = '0;
    bit              got, expired;

    initial forever @(posedge clk or negedge rst) begin
        if (rst !== 1'b1) begin
            running = 1'b0; cur = -1; pulse_at = -1; done_at = -1; wait_from = 0;
            m_fail_map = '0; m_tmo = '0; todo.delete();
        end else begin
            cyc++;
            if (running) begin
                if (done_at == cyc - 1) begin
                    running = 1'b0;
                end else if (cur >= 0 && cyc - 1 >= wait_from) begin
                    got     = (mem_done[cur] === 1'b1);
                    expired = WD && (cyc - 1 - wait_from == TMO);
                    if (got || expired) begin
                        m_fail_map[cur] = got ? mem_fail[cur] : 1'b1;
                        if (!got) m_tmo[cur] = 1'b1;
                        if (todo.size() > 0) begin
                            cur = todo.pop_front(); pulse_at = cyc + 1; wait_from = cyc + 1;
                        end else begin
                            cur = -1; done_at = cyc;
                        end
                    end
                end
            end else if (start === 1'b1) begin
                running = 1'b1; m_fail_map = '0; m_tmo = '0; done_at = -1;
                for (int i = 0; i < NMEM; i++) if (mem_en[i]) todo.push_back(i);
                if (todo.size() == 0) done_at = cyc;
                else begin cur = todo.pop_front(); pulse_at = cyc; wait_from = cyc + 1; end
            end
        end
    end

    // ---------------- engine responder ----------------
    int              due [NMEM] = '{default: -1};
    logic [NMEM-1:0] nd;
    initial forever @(negedge clk) begin
        for (int i = 0; i < NMEM; i++) begin
            if (rst !== 1'b1) due[i] = -1;
            else if (mem_start[i] === 1'b1) due[i] = (lat_cfg[i] == 0) ? -1 : cyc + lat_cfg[i];
            nd[i] = (due[i] == cyc) | spur_done[i];
        end
        mem_done = nd;
        mem_fail = fail_cfg;
    end

    // ---------------- observation log ----------------
    int pl_cyc [$], pl_idx [$], dn_cyc [$];
    int busy_cnt = 0;
    initial forever @(negedge clk) begin
        for (int i = 0; i < NMEM; i++)
            if (mem_start[i] === 1'b1) begin pl_cyc.push_back(cyc); pl_idx.push_back(i); end
        if (done === 1'b1) dn_cyc.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic launch(input logic [NMEM-1:0] mask, output int n);
        @(posedge clk); #1;
        mem_en = mask; start = 1'b1; n = cyc;
        @(posedge clk); #1;
        start = 1'b0; mem_en = ~mask;
    endtask

    task automatic wait_done(input int base, output int d);
        d = -1;
        for (int k = 0; k < 600; k++) begin
            if (dn_cyc.size() > base) begin d = dn_cyc[base]; break; end
            @(posedge clk); #1;
        end
        if (d < 0) chk("done_within_budget", 32'(dn_cyc.size()), 32'(base + 1));
    endtask

    task automatic pin(input string nm, input int base, input int k, input int idx, input int at);
        if (pl_idx.size() <= base + k)
            chk({nm, "_present"}, 32'(pl_idx.size()), 32'(base + k + 1));
        else begin
            chk({nm, "_idx"}, 32'(pl_idx[base + k]), 32'(idx));
            chk({nm, "_cyc"}, 32'(pl_cyc[base + k]), 32'(at));
        end
    endtask

    logic [NMEM-1:0] es;
    int n, d, pb, db, bc;

    initial begin
        fork
            forever @(negedge clk) begin
                es = (cur >= 0 && pulse_at == cyc) ? (NMEM'(1) << cur) : '0;
                chk("mem_start", 32'(mem_start), 32'(es));
                chk("busy", 32'(busy), 32'(running && done_at != cyc));
                chk("done", 32'(done), 32'(running && done_at == cyc));
                chk("fail_map", 32'(fail_map), 32'(m_fail_map));
                chk("fail", 32'(fail), 32'(|m_fail_map));
                chk("timeout_map", 32'(timeout_map), 32'(m_tmo));
            end
        join_none

        #1 rst = 1'b0;
        #1;
        chk("rst_mem_start", 32'(mem_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fail", 32'(fail), 0);
        step(3);
        rst = 1'b1;
        step(2);

        // full run, all pass
        pb = pl_idx.size(); db = dn_cyc.size();
        launch(4'b1111, n);
        wait_done(db, d);
        step(2);
        for (int k = 0; k < 4; k++) pin("t1_pulse", pb, k, k, n + 1 + 22 * k);
        chk("t1_done_cyc", 32'(d), 32'(n + 88));
        chk("t1_npulse", 32'(pl_idx.size() - pb), 4);
        chk("t1_ndone", 32'(dn_cyc.size() - db), 1);
        chk("t1_fail_map", 32'(fail_map), 0);
        chk("t1_fail", 32'(fail), 0);

        // sparse mask, engine 3 fails
        fail_cfg = 4'b1000;
        pb = pl_idx.size(); db = dn_cyc.size();
        launch(4'b1010, n);
        wait_done(db, d);
        step(2);
        pin("t2_p0", pb, 0, 1, n + 1);
        pin("t2_p1", pb, 1, 3, n + 23);
        chk("t2_npulse", 32'(pl_idx.size() - pb), 2);
        chk("t2_done_cyc", 32'(d), 32'(n + 44));
        chk("t2_fail_map", 32'(fail_map), 32'h8);
        chk("t2_fail", 32'(fail), 1);

        // empty mask
        fail_cfg = '0;
        pb = pl_idx.size(); db = dn_cyc.size(); bc = busy_cnt;
        launch(4'b0000, n);
        wait_done(db, d);
        step(2);
        chk("t3_done_cyc", 32'(d), 32'(n + 1));
        chk("t3_busy_cycles", 32'(busy_cnt - bc), 0);
        chk("t3_npulse", 32'(pl_idx.size() - pb), 0);
        chk("t3_fail_map", 32'(fail_map), 0);
        chk("t3_fail", 32'(fail), 0);

        // ignored start / spurious done, engine 1 slow, engine 2 fails
        fail_cfg = 4'b0100; lat_cfg[1] = 30;
        pb = pl_idx.size(); db = dn_cyc.size();
        launch(4'b1111, n);
        goto(n + 5);  start = 1'b1;
        goto(n + 6);  start = 1'b0;
        goto(n + 30); start = 1'b1; spur_done = 4'b0100;
        goto(n + 31); start = 1'b0; spur_done = '0;
        goto(n + 98); start = 1'b1; mem_en = 4'b1111;
        goto(n + 99); start = 1'b0;
        wait_done(db, d);
        step(4);
        pin("t4_p0", pb, 0, 0, n + 1);
        pin("t4_p1", pb, 1, 1, n + 23);
        pin("t4_p2", pb, 2, 2, n + 55);
        pin("t4_p3", pb, 3, 3, n + 77);
        chk("t4_done_cyc", 32'(d), 32'(n + 98));
        chk("t4_npulse", 32'(pl_idx.size() - pb), 4);
        chk("t4_busy_after", 32'(busy), 0);
        chk("t4_fail_map", 32'(fail_map), 32'h4);
        lat_cfg[1] = 20;

        // reset during engine 1's first wait cycle, while its start pulse is high
        fail_cfg = 4'b0001;
        launch(4'b1111, n);
        goto(n + 23);
        chk("t5_pulse_before", 32'(mem_start), 32'h2);
        chk("t5_fmap_before", 32'(fail_map), 32'h1);
        rst = 1'b0;
        #1;
        chk("t5_rst_mem_start", 32'(mem_start), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_fail_map", 32'(fail_map), 0);
        chk("t5_rst_fail", 32'(fail), 0);
        step(3);
        rst = 1'b1;
        fail_cfg = '0;
        pb = pl_idx.size(); db = dn_cyc.size();
        launch(4'b1111, n);
        wait_done(db, d);
        step(2);
        pin("t5_p0", pb, 0, 0, n + 1);
        pin("t5_p3", pb, 3, 3, n + 67);
        chk("t5_done_cyc", 32'(d), 32'(n + 88));

`ifdef MBIST_SCHED_WATCHDOG_EN
        // engine 1 hangs; engine 3 answers exactly on the expiry cycle
        lat_cfg[1] = 0; lat_cfg[3] = 100;
        pb = pl_idx.size(); db = dn_cyc.size();
        launch(4'b1111, n);
        wait_done(db, d);
        step(2);
        pin("t6_p1", pb, 1, 1, n + 23);
        pin("t6_p2", pb, 2, 2, n + 125);
        pin("t6_p3", pb, 3, 3, n + 147);
        chk("t6_done_cyc", 32'(d), 32'(n + 248));
        chk("t6_timeout_map", 32'(timeout_map), 32'h2);
        chk("t6_fail_map", 32'(fail_map), 32'h2);
        chk("t6_fail", 32'(fail), 1);
        lat_cfg[1] = 20; lat_cfg[3] = 20;
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
